// File: rtl/fc_addr_demux.sv
// Address-decoding demultiplexer from one TCDM-style master to N_PORTS slaves.
// Responses return in order through a target-ID FIFO; unmapped addresses get an internal error reply.
module fc_addr_demux #(
  parameter int N_PORTS    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             s_req_i,
  input  logic [ADDR_WIDTH-1:0]            s_addr_i,
  input  logic                             s_wen_i,
  input  logic [DATA_WIDTH-1:0]            s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]          s_be_i,
  output logic                             s_gnt_o,
  output logic                             s_rvalid_o,
  output logic [DATA_WIDTH-1:0]            s_rdata_o,
  output logic                             s_err_o,
  output logic [N_PORTS-1:0]               m_req_o,
  output logic [N_PORTS*ADDR_WIDTH-1:0]    m_addr_o,
  output logic [N_PORTS-1:0]               m_wen_o,
  output logic [N_PORTS*DATA_WIDTH-1:0]    m_wdata_o,
  output logic [N_PORTS*DATA_WIDTH/8-1:0]  m_be_o,
  input  logic [N_PORTS-1:0]               m_gnt_i,
  input  logic [N_PORTS-1:0]               m_rvalid_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0]    m_rdata_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]    rule_base_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]    rule_mask_i,
  output logic [$clog2(MAX_OUTST):0]       outst_o,
  output logic [15:0]                      stall_cnt_o,
  output logic                             proto_err_o
);

  localparam int TW = $clog2(N_PORTS + 1);
  localparam int AW = $clog2(MAX_OUTST);
  localparam int PW = AW + 1;
  localparam logic [TW-1:0]         ERR_ID   = TW'(N_PORTS);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hBADACCE5);

  logic [TW-1:0] r_fifo [MAX_OUTST];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [15:0]   r_stall;
  logic          r_proto;

  logic [TW-1:0] w_tgt;
  logic [TW-1:0] w_head;
  logic [TW-1:0] w_newest;
  logic [AW-1:0] w_wlast;
  logic          w_empty;
  logic          w_full;
  logic          w_accept;
  logic          w_blocked;
  logic          w_pop;
  logic          w_proto;

  assign m_addr_o    = {N_PORTS{s_addr_i}};
  assign m_wen_o     = {N_PORTS{s_wen_i}};
  assign m_wdata_o   = {N_PORTS{s_wdata_i}};
  assign m_be_o      = {N_PORTS{s_be_i}};
  assign outst_o     = r_wptr - r_rptr;
  assign stall_cnt_o = r_stall;
  assign proto_err_o = r_proto;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_wlast  = r_wptr[AW-1:0] - AW'(1);
  assign w_head   = r_fifo[r_rptr[AW-1:0]];
  assign w_newest = r_fifo[w_wlast];

  // Address decode: scan downward so the lowest matching rule wins
  always_comb begin
    w_tgt = ERR_ID;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if ((s_addr_i & rule_mask_i[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (rule_base_i[i*ADDR_WIDTH +: ADDR_WIDTH] & rule_mask_i[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        w_tgt = TW'(i);
      end else begin
        w_tgt = w_tgt;
      end
    end
  end

  // Request routing; switching targets waits until every older response has drained
  always_comb begin
    w_accept  = s_req_i && !rst_i && !w_full && (w_empty || (w_tgt == w_newest));
    w_blocked = s_req_i && !w_accept;
    m_req_o   = '0;
    s_gnt_o   = 1'b0;
    if (w_accept) begin
      if (w_tgt == ERR_ID) begin
        s_gnt_o = 1'b1;
      end else begin
        for (int i = 0; i < N_PORTS; i++) begin
          if (w_tgt == TW'(i)) begin
            m_req_o[i] = 1'b1;
            s_gnt_o    = m_gnt_i[i];
          end else begin
            m_req_o[i] = 1'b0;
          end
        end
      end
    end else begin
      s_gnt_o = 1'b0;
    end
  end

  // Response path: only the FIFO head may answer, any other rvalid is a protocol error
  always_comb begin
    s_rvalid_o = 1'b0;
    s_err_o    = 1'b0;
    s_rdata_o  = '0;
    w_pop      = 1'b0;
    w_proto    = 1'b0;
    if (!rst_i && !w_empty && (w_head == ERR_ID)) begin
      s_rvalid_o = 1'b1;
      s_err_o    = 1'b1;
      s_rdata_o  = ERR_DATA;
      w_pop      = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
    for (int j = 0; j < N_PORTS; j++) begin
      if (m_rvalid_i[j]) begin
        if (!rst_i && !w_empty && (w_head == TW'(j))) begin
          s_rvalid_o = 1'b1;
          s_rdata_o  = m_rdata_i[j*DATA_WIDTH +: DATA_WIDTH];
          w_pop      = 1'b1;
        end else begin
          w_proto = 1'b1;
        end
      end else begin
        w_proto = w_proto;
      end
    end
  end

  // Pointers, stall counter and sticky protocol-error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_stall <= 16'h0000;
      r_proto <= 1'b0;
    end else begin
      if (s_gnt_o) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_blocked && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end
      r_proto <= r_proto | w_proto;
    end
  end

  // ID storage; validity is tracked purely by the pointers
  always_ff @(posedge clk_i) begin
    if (s_gnt_o) begin
      r_fifo[r_wptr[AW-1:0]] <= w_tgt;
    end
  end

endmodule
